// File: rtl/clint_ctrl.sv
// ============================================================================
// Module   : clint_ctrl
// Purpose  : Core-local interruptor. This block holds the machine timer
//            (mtime, mtimecmp) and software-interrupt (msip) registers behind
//            a request/response port. It also drives the registered time_int
//            and soft_int pending lines.
// Options  : CLINT_MTIME_STALL_EN adds a stall_timer input port. While that
//            port is high, the prescaler and mtime hold their values.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module clint_ctrl #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    BASE     = 'h0200_0000,
  parameter int unsigned          TICK_DIV = 1
) (
  input  logic              clock,
  input  logic              reset_n,
`ifdef CLINT_MTIME_STALL_EN
  input  logic              stall_timer,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              time_int,
  output logic              soft_int,
  output logic [63:0]       mtime_o
);

  // Register offsets relative to BASE
  localparam logic [ADDR_W-1:0] OFF_MSIP     = '0;
  localparam logic [ADDR_W-1:0] OFF_MTIMECMP = ADDR_W'(32'h0000_4000);
  localparam logic [ADDR_W-1:0] OFF_MTIME    = ADDR_W'(32'h0000_BFF8);

  // The prescaler needs at least one bit, even when TICK_DIV is 1
  localparam int unsigned       PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]   PS_MAX = PS_W'(TICK_DIV - 1);

  logic              msip;
  logic [63:0]       mtimecmp;
  logic [63:0]       mtime;
  logic [PS_W-1:0]   prescaler;

  logic              msip_next;
  logic [63:0]       mtimecmp_next;
  logic [63:0]       mtime_next;
  logic [PS_W-1:0]   prescaler_next;

  logic              stall;
  logic              tick;
  logic              accept;
  logic              wr;
  logic [ADDR_W-1:0] offset;
  logic              hit_msip;
  logic              hit_mtimecmp;
  logic              hit_mtime;
  logic              mapped;
  logic [63:0]       read_data;

`ifdef CLINT_MTIME_STALL_EN
  assign stall = stall_timer;
`else
  assign stall = 1'b0;
`endif

  // Apply the byte write enables to merge the write data into the old value
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  mask);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Only one response can be outstanding at a time. A new request is
  // accepted in the same cycle that the current response is consumed.
  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign wr        = accept && req_wen;

  assign offset       = req_addr - BASE;
  assign hit_msip     = (offset == OFF_MSIP);
  assign hit_mtimecmp = (offset == OFF_MTIMECMP);
  assign hit_mtime    = (offset == OFF_MTIME);
  assign mapped       = hit_msip || hit_mtimecmp || hit_mtime;

  assign tick         = !stall && (prescaler == PS_MAX);

  // Next-state logic. A CPU write to mtime wins over a tick in the same
  // cycle, and the increment for that tick is dropped.
  always_comb begin
    prescaler_next = prescaler;
    if (!stall) prescaler_next = (prescaler == PS_MAX) ? '0 : prescaler + 1'b1;

    mtime_next = mtime;
    if (wr && hit_mtime)  mtime_next = merge_bytes(mtime, req_wdata, req_wmask);
    else if (tick)        mtime_next = mtime + 64'd1;

    mtimecmp_next = mtimecmp;
    if (wr && hit_mtimecmp) mtimecmp_next = merge_bytes(mtimecmp, req_wdata, req_wmask);

    msip_next = msip;
    if (wr && hit_msip && req_wmask[0]) msip_next = req_wdata[0];
  end

  // Read mux returns the values present before this cycle's updates
  always_comb begin
    read_data = 64'd0;
    if (hit_msip)          read_data = {63'd0, msip};
    else if (hit_mtimecmp) read_data = mtimecmp;
    else if (hit_mtime)    read_data = mtime;
  end

  // Timer and software-interrupt registers, with the registered pending lines
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      msip      <= 1'b0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime     <= 64'd0;
      prescaler <= '0;
      time_int  <= 1'b0;
      soft_int  <= 1'b0;
    end else begin
      msip      <= msip_next;
      mtimecmp  <= mtimecmp_next;
      mtime     <= mtime_next;
      prescaler <= prescaler_next;
      time_int  <= (mtime_next >= mtimecmp_next);
      soft_int  <= msip_next;
    end
  end

  // Response register. Its contents are held until the response is consumed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_rdata <= req_wen ? 64'd0 : read_data;
      resp_err   <= !mapped;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign mtime_o = mtime;

endmodule

`default_nettype wire
